// File: rtl/vx_tex_req_unit.sv
// Texture request unit: tag table that issues tagged sampler requests and rejoins out-of-order
// sampler responses with their metadata. Optional perf counters when TEX_REQ_PERF_EN is defined.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef NTEX_BITS
`define NTEX_BITS 1
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_tex_req_unit #(
  parameter int TAG_COUNT = 4,
  localparam int TAG_BITS = $clog2(TAG_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_valid,
  input  logic [`UUID_BITS-1:0]                req_uuid,
  input  logic [`NW_BITS-1:0]                  req_wid,
  input  logic [`NUM_THREADS-1:0]              req_tmask,
  input  logic [31:0]                          req_PC,
  input  logic [`NR_BITS-1:0]                  req_rd,
  input  logic                                 req_wb,
  input  logic [`NTEX_BITS-1:0]                req_unit,
  input  logic [1:0][`NUM_THREADS-1:0][31:0]   req_coords,
  input  logic [`NUM_THREADS-1:0][31:0]        req_lod,
  output logic                                 req_ready,
  output logic                                 smp_req_valid,
  output logic [TAG_BITS-1:0]                  smp_req_tag,
  output logic [`NTEX_BITS-1:0]                smp_req_unit,
  output logic [`NUM_THREADS-1:0]              smp_req_tmask,
  output logic [1:0][`NUM_THREADS-1:0][31:0]   smp_req_coords,
  output logic [`NUM_THREADS-1:0][31:0]        smp_req_lod,
  input  logic                                 smp_req_ready,
  input  logic                                 smp_rsp_valid,
  input  logic [TAG_BITS-1:0]                  smp_rsp_tag,
  input  logic [`NUM_THREADS-1:0][31:0]        smp_rsp_texels,
  output logic                                 smp_rsp_ready,
  output logic                                 rsp_valid,
  output logic [`UUID_BITS-1:0]                rsp_uuid,
  output logic [`NW_BITS-1:0]                  rsp_wid,
  output logic [`NUM_THREADS-1:0]              rsp_tmask,
  output logic [31:0]                          rsp_PC,
  output logic [`NR_BITS-1:0]                  rsp_rd,
  output logic                                 rsp_wb,
  output logic [`NUM_THREADS-1:0][31:0]        rsp_data,
  input  logic                                 rsp_ready
`ifdef TEX_REQ_PERF_EN
  ,
  output logic [`PERF_CTR_BITS-1:0]            perf_stalls,
  output logic [TAG_BITS:0]                    perf_pending
`endif
);

  // Every channel transfers on a cycle where valid && ready are both high at the clock edge;
  // a producer holds valid and its payload stable until that transfer happens.

  typedef struct packed {
    logic [`UUID_BITS-1:0]   uuid;
    logic [`NW_BITS-1:0]     wid;
    logic [`NUM_THREADS-1:0] tmask;
    logic [31:0]             pc;
    logic [`NR_BITS-1:0]     rd;
    logic                    wb;
  } meta_t;

  logic [TAG_COUNT-1:0] free_mask;
  meta_t                meta_ram [TAG_COUNT];
  meta_t                rsp_meta;
  logic                 any_free;
  logic [TAG_BITS-1:0]  alloc_tag;
  logic                 req_fire;
  logic                 rsp_fire;

  // Lowest-index free tag wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_tag = TAG_BITS'(i);
    end
  end

  assign any_free      = |free_mask;
  assign req_ready     = !reset && any_free && (!smp_req_valid || smp_req_ready);
  assign req_fire      = req_valid && req_ready;
  assign smp_rsp_ready = !rsp_valid || rsp_ready;
  assign rsp_fire      = smp_rsp_valid && smp_rsp_ready;

  // Allocation decodes the pre-edge mask, so a tag freed this cycle is only visible next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask <= '1;
    end else begin
      if (rsp_fire) free_mask[smp_rsp_tag] <= 1'b1;
      if (req_fire) free_mask[alloc_tag] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) meta_ram[alloc_tag] <= {req_uuid, req_wid, req_tmask, req_PC, req_rd, req_wb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_req_valid  <= 1'b0;
      smp_req_tag    <= '0;
      smp_req_unit   <= '0;
      smp_req_tmask  <= '0;
      smp_req_coords <= '0;
      smp_req_lod    <= '0;
    end else if (req_fire) begin
      smp_req_valid  <= 1'b1;
      smp_req_tag    <= alloc_tag;
      smp_req_unit   <= req_unit;
      smp_req_tmask  <= req_tmask;
      smp_req_coords <= req_coords;
      smp_req_lod    <= req_lod;
    end else if (smp_req_ready) begin
      smp_req_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_meta  <= '0;
      rsp_data  <= '0;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b1;
      rsp_meta  <= meta_ram[smp_rsp_tag];
      rsp_data  <= smp_rsp_texels;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_uuid  = rsp_meta.uuid;
  assign rsp_wid   = rsp_meta.wid;
  assign rsp_tmask = rsp_meta.tmask;
  assign rsp_PC    = rsp_meta.pc;
  assign rsp_rd    = rsp_meta.rd;
  assign rsp_wb    = rsp_meta.wb;

  always_ff @(posedge clk) begin
    if (!reset && rsp_fire) begin
      assert (!free_mask[smp_rsp_tag])
        else $error("vx_tex_req_unit: sampler response for free tag %0d", smp_rsp_tag);
    end
  end

`ifdef TEX_REQ_PERF_EN
  localparam int PCW = `PERF_CTR_BITS;
  logic [TAG_BITS:0] busy_cnt;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (!free_mask[i]) busy_cnt = busy_cnt + (TAG_BITS + 1)'(1);
    end
  end

  assign perf_pending = busy_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (req_valid && !req_ready) begin
      perf_stalls <= perf_stalls + PCW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vx_tex_req_unit.sv
// Bench for vx_tex_req_unit: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a tag-table reference model that tracks allocation and completion.
`timescale 1ns/1ps
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef NTEX_BITS
`define NTEX_BITS 1
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_tex_req_unit;
  localparam int TAG_COUNT = 4;
  localparam int TAG_BITS  = 2;
  localparam int NT        = `NUM_THREADS;
  localparam int CW        = 512;

  typedef struct packed {
    logic [TAG_BITS-1:0]        tag;
    logic [`NTEX_BITS-1:0]      unit;
    logic [NT-1:0]              tmask;
    logic [1:0][NT-1:0][31:0]   coords;
    logic [NT-1:0][31:0]        lod;
  } smp_t;

  typedef struct packed {
    logic [`UUID_BITS-1:0] uuid;
    logic [`NW_BITS-1:0]   wid;
    logic [NT-1:0]         tmask;
    logic [31:0]           pc;
    logic [`NR_BITS-1:0]   rd;
    logic                  wb;
  } meta_t;

  typedef struct packed {
    meta_t               meta;
    logic [NT-1:0][31:0] data;
  } wb_t;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [NT-1:0][31:0] texels;
  } force_t;

  // clock / reset / DUT signals
  logic                       clk;
  logic                       reset;
  logic                       req_valid;
  logic [`UUID_BITS-1:0]      req_uuid;
  logic [`NW_BITS-1:0]        req_wid;
  logic [NT-1:0]              req_tmask;
  logic [31:0]                req_PC;
  logic [`NR_BITS-1:0]        req_rd;
  logic                       req_wb;
  logic [`NTEX_BITS-1:0]      req_unit;
  logic [1:0][NT-1:0][31:0]   req_coords;
  logic [NT-1:0][31:0]        req_lod;
  logic                       req_ready;
  logic                       smp_req_valid;
  logic [TAG_BITS-1:0]        smp_req_tag;
  logic [`NTEX_BITS-1:0]      smp_req_unit;
  logic [NT-1:0]              smp_req_tmask;
  logic [1:0][NT-1:0][31:0]   smp_req_coords;
  logic [NT-1:0][31:0]        smp_req_lod;
  logic                       smp_req_ready;
  logic                       smp_rsp_valid;
  logic [TAG_BITS-1:0]        smp_rsp_tag;
  logic [NT-1:0][31:0]        smp_rsp_texels;
  logic                       smp_rsp_ready;
  logic                       rsp_valid;
  logic [`UUID_BITS-1:0]      rsp_uuid;
  logic [`NW_BITS-1:0]        rsp_wid;
  logic [NT-1:0]              rsp_tmask;
  logic [31:0]                rsp_PC;
  logic [`NR_BITS-1:0]        rsp_rd;
  logic                       rsp_wb;
  logic [NT-1:0][31:0]        rsp_data;
  logic                       rsp_ready;
`ifdef TEX_REQ_PERF_EN
  logic [`PERF_CTR_BITS-1:0]  perf_stalls;
  logic [TAG_BITS:0]          perf_pending;
`endif

  vx_tex_req_unit #(.TAG_COUNT(TAG_COUNT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid), .req_tmask(req_tmask),
    .req_PC(req_PC), .req_rd(req_rd), .req_wb(req_wb), .req_unit(req_unit),
    .req_coords(req_coords), .req_lod(req_lod), .req_ready(req_ready),
    .smp_req_valid(smp_req_valid), .smp_req_tag(smp_req_tag), .smp_req_unit(smp_req_unit),
    .smp_req_tmask(smp_req_tmask), .smp_req_coords(smp_req_coords), .smp_req_lod(smp_req_lod),
    .smp_req_ready(smp_req_ready),
    .smp_rsp_valid(smp_rsp_valid), .smp_rsp_tag(smp_rsp_tag), .smp_rsp_texels(smp_rsp_texels),
    .smp_rsp_ready(smp_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask),
    .rsp_PC(rsp_PC), .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
`ifdef TEX_REQ_PERF_EN
    , .perf_stalls(perf_stalls), .perf_pending(perf_pending)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / reference model (negedge) ----------------
  int     errors = 0;
  int     checks = 0;
  int     cycles = 0;
  bit     done = 0;
  bit     hang = 0;
  bit     m_busy [TAG_COUNT];
  meta_t  m_meta [TAG_COUNT];
  bit     m_smp_full = 0;
  bit     m_rsp_full = 0;
  bit     m_chk_zero = 0;
  smp_t   smp_exp_q [$];
  wb_t    wb_exp_q [$];
`ifdef TEX_REQ_PERF_EN
  logic [`PERF_CTR_BITS-1:0] m_stalls = '0;
`endif

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit   any_free, exp_ready, fire_req, fire_rsp;
    int   alloc;
    smp_t act_s, exp_s;
    wb_t  act_w, exp_w;
    cycles++;
    act_s = {smp_req_tag, smp_req_unit, smp_req_tmask, smp_req_coords, smp_req_lod};
    act_w = {rsp_uuid, rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data};
    check("smp_req_valid", CW'(smp_req_valid), CW'(m_smp_full));
    check("rsp_valid", CW'(rsp_valid), CW'(m_rsp_full));
`ifdef TEX_REQ_PERF_EN
    begin
      int pend;
      pend = 0;
      for (int i = 0; i < TAG_COUNT; i++) if (m_busy[i]) pend++;
      check("perf_pending", CW'(perf_pending), CW'(pend));
      check("perf_stalls", CW'(perf_stalls), CW'(m_stalls));
    end
`endif
    if (reset) begin
      check("req_ready_in_reset", CW'(req_ready), CW'(0));
      for (int i = 0; i < TAG_COUNT; i++) m_busy[i] = 0;
      m_smp_full = 0;
      m_rsp_full = 0;
      m_chk_zero = 1;
      smp_exp_q.delete();
      wb_exp_q.delete();
`ifdef TEX_REQ_PERF_EN
      m_stalls = '0;
`endif
    end else begin
      if (m_chk_zero) begin
        check("smp_fields_after_reset", CW'(act_s), CW'(0));
        check("rsp_fields_after_reset", CW'(act_w), CW'(0));
        m_chk_zero = 0;
      end
      any_free = 0;
      alloc = -1;
      for (int i = 0; i < TAG_COUNT; i++) begin
        if (!m_busy[i]) begin
          any_free = 1;
          if (alloc < 0) alloc = i;
        end
      end
      exp_ready = any_free && (!m_smp_full || smp_req_ready);
      check("req_ready", CW'(req_ready), CW'(exp_ready));
      check("smp_rsp_ready", CW'(smp_rsp_ready), CW'(!m_rsp_full || rsp_ready));
      if (m_smp_full) begin
        check("smp_exp_q_nonempty", CW'(smp_exp_q.size() != 0), CW'(1));
        if (smp_exp_q.size() != 0) begin
          check("smp_req_fields", CW'(act_s), CW'(smp_exp_q[0]));
          if (smp_req_ready) void'(smp_exp_q.pop_front());
        end
      end
      if (m_rsp_full) begin
        check("wb_exp_q_nonempty", CW'(wb_exp_q.size() != 0), CW'(1));
        if (wb_exp_q.size() != 0) begin
          check("rsp_fields", CW'(act_w), CW'(wb_exp_q[0]));
          if (rsp_ready) void'(wb_exp_q.pop_front());
        end
      end
      fire_req = req_valid && exp_ready;
      fire_rsp = smp_rsp_valid && (!m_rsp_full || rsp_ready);
`ifdef TEX_REQ_PERF_EN
      if (req_valid && !exp_ready) m_stalls = m_stalls + 1'b1;
`endif
      if (fire_rsp) begin
        exp_w.meta = m_meta[smp_rsp_tag];
        exp_w.data = smp_rsp_texels;
        wb_exp_q.push_back(exp_w);
      end
      if (fire_req) begin
        m_meta[alloc] = {req_uuid, req_wid, req_tmask, req_PC, req_rd, req_wb};
        exp_s = {TAG_BITS'(alloc), req_unit, req_tmask, req_coords, req_lod};
        smp_exp_q.push_back(exp_s);
      end
      if (fire_rsp) m_busy[smp_rsp_tag] = 0;
      if (fire_req) m_busy[alloc] = 1;
      m_smp_full = fire_req || (m_smp_full && !smp_req_ready);
      m_rsp_full = fire_rsp || (m_rsp_full && !rsp_ready);
    end
    if (cycles > 20000) begin
      checks++;
      errors++;
      $display("FAIL watchdog: cycles=%0d limit=20000", cycles);
      done = 1;
    end
    if (done) begin
      check("smp_exp_q_drained", CW'(smp_exp_q.size()), CW'(0));
      check("wb_exp_q_drained", CW'(wb_exp_q.size()), CW'(0));
      check("no_wait_timeout", CW'(hang), CW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- driver (single process: main initial + tasks) ----------------
  int     smp_ready_mode = 0;  // 0: always ready, 1: random
  int     rsp_mode = 0;        // 0: hold, 1: random completion, 2: forced tag order
  int     wb_mode = 0;         // 0: ready, 1: random, 2: stalled
  bit     last_acc = 0;
  int     out_tags [$];
  force_t force_q [$];

  task automatic present(input int tag, input logic [NT-1:0][31:0] tex);
    smp_rsp_valid  = 1'b1;
    smp_rsp_tag    = TAG_BITS'(tag);
    smp_rsp_texels = tex;
  endtask

  task automatic tick();
    bit taken, drop;
    logic [NT-1:0][31:0] tex;
    @(negedge clk);
    last_acc = req_valid && req_ready && !reset;
    taken = smp_rsp_valid && smp_rsp_ready;
    drop = reset;
    if (reset) out_tags.delete();
    else if (smp_req_valid && smp_req_ready) out_tags.push_back(int'(smp_req_tag));
    @(posedge clk);
    #1;
    if (last_acc) req_valid = 1'b0;
    if (taken || drop) smp_rsp_valid = 1'b0;
    smp_req_ready = (smp_ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    rsp_ready = (wb_mode == 0) ? 1'b1 : (wb_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!smp_rsp_valid && !reset) begin
      if (rsp_mode == 1 && out_tags.size() > 0 && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, out_tags.size() - 1);
        for (int t = 0; t < NT; t++) tex[t] = $urandom();
        present(out_tags[k], tex);
        out_tags.delete(k);
      end else if (rsp_mode == 2 && force_q.size() > 0) begin
        for (int k = 0; k < out_tags.size(); k++) begin
          if (!smp_rsp_valid && out_tags[k] == int'(force_q[0].tag)) begin
            present(out_tags[k], force_q[0].texels);
            out_tags.delete(k);
            void'(force_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic set_req(input logic [`NW_BITS-1:0] wid, input logic [`NR_BITS-1:0] rd,
                         input logic [NT-1:0] tmask);
    req_valid = 1'b1;
    req_uuid  = `UUID_BITS'({$urandom(), $urandom()});
    req_wid   = wid;
    req_rd    = rd;
    req_tmask = tmask;
    req_PC    = $urandom();
    req_wb    = 1'($urandom_range(0, 1));
    req_unit  = `NTEX_BITS'($urandom());
    for (int t = 0; t < NT; t++) begin
      req_coords[0][t] = $urandom();
      req_coords[1][t] = $urandom();
      req_lod[t]       = $urandom();
    end
  endtask

  task automatic set_rand_req();
    set_req(`NW_BITS'($urandom()), `NR_BITS'($urandom()), NT'($urandom()));
  endtask

  task automatic issue_wait();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 60);
    if (!last_acc) begin
      hang = 1;
      req_valid = 1'b0;
    end
  endtask

  task automatic push_force(input int tag);
    force_t f;
    f.tag = TAG_BITS'(tag);
    for (int t = 0; t < NT; t++) f.texels[t] = $urandom();
    force_q.push_back(f);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((out_tags.size() != 0 || force_q.size() != 0 || smp_rsp_valid || smp_req_valid ||
            rsp_valid) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) hang = 1;
  endtask

  initial begin : main
    force_t f;
    reset = 1'b1;
    req_valid = 1'b0;
    req_uuid = '0; req_wid = '0; req_tmask = '0; req_PC = '0; req_rd = '0; req_wb = 1'b0;
    req_unit = '0; req_coords = '0; req_lod = '0;
    smp_req_ready = 1'b1;
    smp_rsp_valid = 1'b0; smp_rsp_tag = '0; smp_rsp_texels = '0;
    rsp_ready = 1'b1;

    // reset with a request presented: must not be accepted
    set_rand_req();
    repeat (3) tick();
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    // single request, sampler answers tag 0 about three cycles later
    set_req(2'd2, 5'd5, 4'b1011);
    issue_wait();
    repeat (2) tick();
    f.tag = '0;
    for (int t = 0; t < NT; t++) f.texels[t] = 32'hA5A5A5A5;
    force_q.push_back(f);
    rsp_mode = 2;
    wait_idle(50);

    // fill the table, fifth request stalls, then tag 2 returns and is reused
    rsp_mode = 0;
    for (int k = 0; k < 4; k++) begin
      set_rand_req();
      issue_wait();
    end
    set_rand_req();
    repeat (4) tick();
    push_force(2);
    rsp_mode = 2;
    issue_wait();
    push_force(0); push_force(1); push_force(3); push_force(2);
    wait_idle(80);

    // out-of-order completion: issue 0,1,2 and return 2,0,1
    rsp_mode = 0;
    for (int k = 0; k < 3; k++) begin
      set_rand_req();
      issue_wait();
    end
    push_force(2); push_force(0); push_force(1);
    rsp_mode = 2;
    wait_idle(60);

    // writeback stalled for 10 cycles with a second response queued behind it
    rsp_mode = 0;
    wb_mode = 2;
    for (int k = 0; k < 2; k++) begin
      set_rand_req();
      issue_wait();
    end
    push_force(1); push_force(0);
    rsp_mode = 2;
    repeat (10) tick();
    wb_mode = 0;
    wait_idle(60);

    // randomized traffic
    smp_ready_mode = 1;
    wb_mode = 1;
    rsp_mode = 1;
    repeat (600) begin
      if (!req_valid && $urandom_range(0, 3) != 0) set_rand_req();
      tick();
    end
    if (req_valid) issue_wait();
    smp_ready_mode = 0;
    wb_mode = 0;
    wait_idle(400);

    // reset with three tags busy, then all four tags must be available again
    rsp_mode = 0;
    for (int k = 0; k < 3; k++) begin
      set_rand_req();
      issue_wait();
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_rand_req();
      issue_wait();
    end
    rsp_mode = 1;
    wait_idle(300);

    done = 1;
    repeat (20) @(posedge clk);
    $display("FAIL end_of_test: monitor did not finish, done=%0d", done);
    $fatal(1);
  end

endmodule
